// File: rtl/uart_tx_ctrl.sv
// UART transmitter with a small byte FIFO in front of an 8N1 serialiser.
// The CPU pushes bytes; the FSM pops them and sends frames back-to-back
// while the FIFO holds data. The serial line and tx_done are registered.
module uart_tx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       clr_ovf,
    output logic       UART_TX,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       overflow
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BIT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_PRE   = BIT_W'(CLKS_PER_BIT - 2);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e           state_q;
    logic [BIT_W-1:0] bit_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             done_q;
    logic             ovf_q;

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic push;
    logic pop;
    logic bit_end;

    // Full is judged on the registered count, so a pop on the same edge never
    // makes room for a write.
    assign tx_full  = (count_q == DEPTH_CNT);
    assign tx_empty = (count_q == '0);
    assign push     = wr_en & ~tx_full;
    assign bit_end  = (bit_cnt_q == BIT_LAST);
    assign pop      = ~tx_empty & ((state_q == StIdle) | ((state_q == StStop) & bit_end));

    assign UART_TX  = tx_q;
    assign tx_busy  = (state_q != StIdle);
    assign tx_done  = done_q;
    assign overflow = ovf_q;

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge sysclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Sticky overflow: a dropped write outranks a clear on the same edge.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else if (wr_en && tx_full) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    // Frame FSM; tx_q is loaded on the same edge as each state/bit change.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    bit_cnt_q <= '0;
                    bit_idx_q <= '0;
                    if (pop) begin
                        state_q <= StStart;
                        shift_q <= mem_q[rd_ptr_q];
                        tx_q    <= 1'b0;
                    end else begin
                        tx_q <= 1'b1;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        bit_cnt_q <= '0;
                        state_q   <= StData;
                        tx_q      <= shift_q[0];
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    end
                end
                StData: begin
                    if (bit_end) begin
                        bit_cnt_q <= '0;
                        shift_q   <= {1'b0, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_q <= '0;
                            state_q   <= StStop;
                            tx_q      <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    end
                end
                StStop: begin
                    // Raise done so it is visible during the final stop cycle.
                    if (bit_cnt_q == BIT_PRE) done_q <= 1'b1;
                    if (bit_end) begin
                        bit_cnt_q <= '0;
                        if (pop) begin
                            state_q <= StStart;
                            shift_q <= mem_q[rd_ptr_q];
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: a directed vector table, hand-written corner
// sequences and a randomized run, all checked against a frame-level model.
module tb_uart_tx_ctrl;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       sysclk;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_ovf;
    logic       UART_TX;
    logic       tx_full;
    logic       tx_empty;
    logic       tx_busy;
    logic       tx_done;
    logic       overflow;

    uart_tx_ctrl #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .sysclk  (sysclk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .clr_ovf (clr_ovf),
        .UART_TX (UART_TX),
        .tx_full (tx_full),
        .tx_empty(tx_empty),
        .tx_busy (tx_busy),
        .tx_done (tx_done),
        .overflow(overflow)
    );

    initial begin
        sysclk = 1'b0;
        forever #5 sysclk = ~sysclk;
    end

    int n_total = 0;
    int n_pass  = 0;

    // Output vector order: {tx, full, empty, busy, done, ovf}
    localparam logic [5:0] RESET_VEC = 6'b101000;

    typedef struct {
        logic       we;
        logic [7:0] data;
        logic       clr;
        int         cycles;
        logic [5:0] exp;
    } vec_t;

    // Frame-level reference: pending bytes, position within the current frame.
    logic [7:0] mq[$];
    bit         m_busy;
    int         m_t;
    logic [7:0] m_byte;
    bit         m_ovf;

    function automatic void model_reset();
        mq.delete();
        m_busy = 1'b0;
        m_t    = 0;
        m_byte = 8'h00;
        m_ovf  = 1'b0;
    endfunction

    function automatic void model_edge(input logic we, input logic [7:0] d, input logic clr);
        bit full = (mq.size() == DEPTH);
        bit had  = (mq.size() != 0);
        if (m_busy) begin
            m_t++;
            if (m_t == FRAME) begin
                if (had) begin
                    m_byte = mq.pop_front();
                    m_t    = 0;
                end else begin
                    m_busy = 1'b0;
                end
            end
        end else if (had) begin
            m_byte = mq.pop_front();
            m_t    = 0;
            m_busy = 1'b1;
        end
        if (we && !full) mq.push_back(d);
        if (we && full) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endfunction

    function automatic logic [5:0] model_outs();
        logic tx;
        int   slot = m_t / CPB;
        if (!m_busy)        tx = 1'b1;
        else if (slot == 0) tx = 1'b0;
        else if (slot <= 8) tx = m_byte[3'(slot - 1)];
        else                tx = 1'b1;
        return {tx, mq.size() == DEPTH, mq.size() == 0, m_busy,
                m_busy && (m_t == FRAME - 1), m_ovf};
    endfunction

    function automatic logic [5:0] dut_outs();
        return {UART_TX, tx_full, tx_empty, tx_busy, tx_done, overflow};
    endfunction

    task automatic check_bits(input string name, input logic [5:0] got, input logic [5:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %b expected %b {tx,full,empty,busy,done,ovf} at %0t",
                     name, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_total++;
        if (got != exp)
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        else
            n_pass++;
    endtask

    // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
    task automatic step(input logic we, input logic [7:0] d, input logic clr);
        wr_en   = we;
        wr_data = d;
        clr_ovf = clr;
        model_edge(we, d, clr);
        @(posedge sysclk);
        #1;
        check_bits("model", dut_outs(), model_outs());
    endtask

    task automatic do_reset(input string name);
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
        reset   = 1'b0;
        #1;
        model_reset();
        check_bits(name, dut_outs(), RESET_VEC);
        repeat (2) @(posedge sysclk);
        #1;
        reset = 1'b1;
    endtask

    // Idle until the transmitter is idle with an empty FIFO, or the budget runs out.
    task automatic drain(input string name, input int budget, output int dones,
                         output int busy_cycles);
        bit finished = 1'b0;
        dones       = 0;
        busy_cycles = 0;
        for (int i = 0; i < budget && !finished; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (tx_done) dones++;
            if (tx_busy) busy_cycles++;
            if (!tx_busy && tx_empty) finished = 1'b1;
        end
        check_int({name, "_drained"}, int'(finished), 1);
    endtask

    initial begin
        vec_t       tbl[$];
        logic [7:0] a5;
        int         dones;
        int         busy;
        int         lows;
        bit         seen;
        int         pct;

        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        clr_ovf = 1'b0;
        model_reset();

        // Single 0xA5 frame from idle: start, LSB-first data, stop with done pulse.
        a5 = 8'hA5;
        tbl.push_back('{1'b1, 8'hA5, 1'b0, 1, 6'b100000});
        tbl.push_back('{1'b0, 8'h00, 1'b0, CPB, 6'b001100});
        for (int b = 0; b < 8; b++)
            tbl.push_back('{1'b0, 8'h00, 1'b0, CPB, a5[b] ? 6'b101100 : 6'b001100});
        tbl.push_back('{1'b0, 8'h00, 1'b0, CPB - 1, 6'b101100});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 1, 6'b101110});
        tbl.push_back('{1'b0, 8'h00, 1'b0, 2, 6'b101000});

        #2;
        do_reset("reset_init");

        for (int i = 0; i < tbl.size(); i++) begin
            for (int c = 0; c < tbl[i].cycles; c++) begin
                step(tbl[i].we, tbl[i].data, tbl[i].clr);
                check_bits($sformatf("vec%0d_c%0d", i, c), dut_outs(), tbl[i].exp);
            end
        end

        // Two consecutive writes: frames abut with no idle bit between them.
        step(1'b1, 8'h55, 1'b0);
        step(1'b1, 8'hAA, 1'b0);
        drain("b2b", 300, dones, busy);
        check_int("b2b_dones", dones, 2);
        // Busy from the second write edge for 2*FRAME samples; that edge is already past.
        check_int("b2b_busy_cycles", busy, 2 * FRAME - 1);
        check_int("b2b_empty", int'(tx_empty), 1);

        // Six writes while idle: one popped, four queued, the sixth dropped.
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
        check_int("burst_ovf", int'(overflow), 1);
        check_int("burst_full", int'(tx_full), 1);
        drain("burst", 600, dones, busy);
        check_int("burst_frames", dones, 5);

        // Full FIFO written on the very edge STOP pops: the write is still dropped.
        step(1'b0, 8'h00, 1'b1);
        check_int("clr_ovf", int'(overflow), 0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hB1 + i), 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (tx_done) seen = 1'b1;
        end
        check_int("pop_edge_found", int'(seen), 1);
        step(1'b1, 8'hEE, 1'b0);
        check_int("pop_edge_ovf", int'(overflow), 1);
        check_int("pop_edge_full", int'(tx_full), 0);
        drain("pop_edge", 400, dones, busy);
        check_int("pop_edge_frames", dones, 4);

        // Reset in data bit 3 with two bytes queued: line high and FIFO empty at once.
        step(1'b1, 8'hC1, 1'b0);
        step(1'b1, 8'hC2, 1'b0);
        step(1'b1, 8'hC3, 1'b0);
        for (int i = 0; i < 3 * CPB + CPB - 1; i++) step(1'b0, 8'h00, 1'b0);
        check_int("mid_busy", int'(tx_busy), 1);
        do_reset("reset_mid_frame");
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (!UART_TX || tx_busy) lows++;
        end
        check_int("post_reset_quiet", lows, 0);

        // Clear coinciding with a dropping write: set wins; a lone clear then clears.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hD1 + i), 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        check_int("set_beats_clr", int'(overflow), 1);
        step(1'b0, 8'h00, 1'b1);
        check_int("clr_after_set", int'(overflow), 0);
        drain("clr_seq", 600, dones, busy);

        // Randomized traffic at several write densities, with rare resets.
        do_reset("reset_rand");
        for (int seg = 0; seg < 6; seg++) begin
            pct = (seg % 3 == 0) ? 2 : ((seg % 3 == 1) ? 6 : 30);
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 1499) == 0) begin
                    do_reset("reset_rand_mid");
                end else begin
                    step($urandom_range(0, 99) < pct, 8'($urandom_range(0, 255)),
                         $urandom_range(0, 39) == 0);
                end
            end
        end
        drain("rand_final", 600, dones, busy);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 10416: sysclk cycles per UART bit (100 MHz / 9600 baud); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: byte FIFO entries; power of two, 2..16.
REQ-003 SHALL have port sysclk  input  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port wr_en  input  1: CPU store strobe; enqueues wr_data on the sampled edge.
REQ-006 SHALL have port wr_data  input  8: byte to transmit.
REQ-007 SHALL have port clr_ovf  input  1: clears the overflow flag.
REQ-008 SHALL have port UART_TX  output  1: serial line, 8N1, LSB first, idle high.
REQ-009 SHALL have port tx_full  output  1: FIFO count == FIFO_DEPTH.
REQ-010 SHALL have port tx_empty  output  1: FIFO count == 0.
REQ-011 SHALL have port tx_busy  output  1: FSM not in IDLE.
REQ-012 SHALL have port tx_done  output  1: one-cycle pulse at the end of each stop bit.
REQ-013 SHALL have port overflow  output  1: sticky flag; a write was dropped.

Function
REQ-014 SHALL contain a FIFO_DEPTH x 8 circular buffer with wrapping read/write pointers and a count register 0..FIFO_DEPTH.
REQ-015 SHALL enqueue wr_data when wr_en=1 and tx_full=0, with tx_full evaluated before any same-cycle pop.
REQ-016 SHALL drop the byte and set overflow when wr_en=1 and tx_full=1; count and pointers unchanged by the write.
REQ-017 SHALL, on a same-cycle push and pop, leave count unchanged and advance both pointers.
REQ-018 SHALL use FSM states IDLE, START, DATA, STOP; one bit counter (0..CLKS_PER_BIT-1) and one bit index (0..7).
REQ-019 SHALL transition IDLE->START when tx_empty=0, popping the head byte into an 8-bit shift register on that same edge.
REQ-020 SHALL drive UART_TX=0 in START for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-021 SHALL drive UART_TX=shift[0] in DATA, each bit held CLKS_PER_BIT cycles, shift right after each bit, and enter STOP after bit 7.
REQ-022 SHALL drive UART_TX=1 in STOP for CLKS_PER_BIT cycles; on its last cycle pulse tx_done=1.
REQ-023 SHALL, leaving STOP with FIFO non-empty, pop and go directly to START (back-to-back frames, no idle bit); else go to IDLE.
REQ-024 SHALL drive UART_TX=1 in IDLE.
REQ-025 SHALL register UART_TX (glitch-free output); first start-bit low appears the cycle after IDLE->START.
REQ-026 SHALL give frame latency of 1 cycle (write edge) + 1 cycle (IDLE->START edge) before UART_TX falls when idle.
REQ-027 SHALL give frame length of exactly 10*CLKS_PER_BIT cycles.
REQ-028 SHALL clear overflow when clr_ovf=1; if overflow-set and clr_ovf coincide, set wins.
REQ-029 SHALL not alter shift register or pointers for a frame already in progress on any write.

Reset
REQ-030 SHALL, on reset=0 asynchronously: FSM=IDLE, counters=0, pointers=0, count=0, UART_TX=1, tx_empty=1, tx_full=0, tx_busy=0, tx_done=0, overflow=0.
REQ-031 SHALL, on reset mid-frame, abort the frame and discard all FIFO contents; UART_TX goes high immediately.
REQ-032 SHALL resume normal operation on the first sysclk edge after reset returns to 1.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-033 SHALL verify: write 0xA5 while idle -> UART_TX low 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), high 4 cycles; tx_done one pulse; total 40 cycles.
REQ-034 SHALL verify: write 0x55,0xAA on consecutive cycles -> two 40-cycle frames back-to-back, no idle gap, two tx_done pulses, tx_empty=1 afterwards.
REQ-035 SHALL verify: 6 writes on consecutive cycles while idle -> first popped, next 4 queued, 6th dropped; overflow=1; exactly 5 frames transmitted.
REQ-036 SHALL verify: write when tx_full=1 on the same cycle STOP pops -> byte dropped, overflow=1, count stays 4 after the pop-only edge minus 1 (=3).
REQ-037 SHALL verify: reset=0 during DATA bit 3 with 2 bytes queued -> UART_TX=1 and tx_empty=1 immediately; no frame after release until a new write.
REQ-038 SHALL verify: overflow set, clr_ovf=1 one cycle -> overflow=0; clr_ovf with a dropping write on the same cycle -> overflow=1.
